// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller:
// FSM state encoding, PC source codes, XZR index and watchdog limit.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_ERROR   = 2'd2;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_REL = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    localparam logic [4:0] XZR_IDX    = 5'd31;
    localparam logic [3:0] WDOG_LIMIT = 4'd15;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard compare between ID/EX destination and IF/ID sources.
// XZR is never a real producer, so it never raises a hazard.
module pipe_hazard_detect (
    input  logic [4:0] id_rn,
    input  logic [4:0] id_rm,
    input  logic       id_uses_rm,
    input  logic       idex_memread,
    input  logic [4:0] idex_rd,
    output logic       load_use
);
    import pipe_ctrl_pkg::*;

    logic rn_hit;
    logic rm_hit;

    assign rn_hit = (idex_rd == id_rn);
    assign rm_hit = id_uses_rm & (idex_rd == id_rm);

    assign load_use = idex_memread
                    & (idex_rd != XZR_IDX)
                    & (rn_hit | rm_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall/flush controller with data-memory watchdog.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic        id_uses_rm,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rd,
    input  logic        exmem_branch,
    input  logic        exmem_uncondbranch,
    input  logic        exmem_branchreg,
    input  logic        exmem_zero,
    input  logic        exmem_not_zero,
    input  logic        exmem_memread,
    input  logic        exmem_memwrite,
    output logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_hold,
    output logic        idex_bubble,
    output logic        exmem_hold,
    output logic        exmem_flush,
    output logic        memwb_bubble,
    output logic        wdog_err,
    output logic [1:0]  pc_src,
    output logic [1:0]  state,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);
    import pipe_ctrl_pkg::*;

    logic [1:0] state_q, state_nxt;
    logic [3:0] wdog_q, wdog_nxt;
    logic       load_use, taken, mem_req;
    logic       err_c, stall_c, redir_c, lu_c;

    pipe_hazard_detect u_detect (
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_uses_rm   (id_uses_rm),
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .load_use     (load_use)
    );

    assign taken = exmem_uncondbranch
                 | exmem_branchreg
                 | (exmem_branch & ~exmem_not_zero & exmem_zero)
                 | (exmem_branch & exmem_not_zero & ~exmem_zero);

    assign mem_req = exmem_memread | exmem_memwrite;

    // Mutually exclusive priority terms: ERROR > mem stall > taken > load-use
    assign err_c   = (state_q == ST_ERROR);
    assign stall_c = ~err_c & mem_req & ~dmem_ready;
    assign redir_c = ~err_c & ~stall_c & taken;
    assign lu_c    = ~err_c & ~stall_c & ~taken & load_use;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_bubble  = 1'b0;
        exmem_hold   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        wdog_err     = 1'b0;
        pc_src       = PC_SEQ;
        dmem_req     = mem_req;
        state_nxt    = ST_RUN;
        wdog_nxt     = 4'd0;
        unique case (1'b1)
            err_c: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_hold    = 1'b1;
                exmem_hold   = 1'b1;
                memwb_bubble = 1'b1;
                wdog_err     = 1'b1;
                dmem_req     = 1'b0;
                state_nxt    = ST_ERROR;
                wdog_nxt     = wdog_q;
            end
            stall_c: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_hold    = 1'b1;
                exmem_hold   = 1'b1;
                memwb_bubble = 1'b1;
                state_nxt    = ST_MEMWAIT;
                if (state_q == ST_MEMWAIT) begin
                    wdog_nxt = wdog_q + 4'd1;
                    if (wdog_nxt == WDOG_LIMIT)
                        state_nxt = ST_ERROR;
                end
            end
            redir_c: begin
                pc_src      = exmem_branchreg ? PC_REG : PC_REL;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_flush = 1'b1;
            end
            lu_c: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            wdog_q  <= 4'd0;
        end else begin
            state_q <= state_nxt;
            wdog_q  <= wdog_nxt;
        end
    end

    assign state = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (!pc_write)
                stall_q <= stall_q + 32'd1;
            if (ifid_flush)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule
